// File: rtl/horizontal_counter_generator.sv
// Horizontal timing for a 640x480@60 VGA raster: pixel divider, line counter,
// registered HSYNC, active-window decode and 128-column scaled index.
module horizontal_counter_generator #(
  parameter int CLK_DIV  = 2,
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int SCALE    = 5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hor_cnt,
  output logic [6:0] scl_hor_cnt,
  output logic       hor_active,
  output logic       new_line,
  output logic       HSYNC
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]      HC_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]      HS_END   = 10'(H_SYNC);
  localparam logic [9:0]      ACT_FIRST = 10'(H_SYNC + H_BP);
  localparam logic [9:0]      ACT_LAST  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [2:0]      INT_LAST = 3'(SCALE - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_hor_cnt;
  logic [2:0]       r_int_cnt;
  logic [6:0]       r_scl_hor_cnt;
  logic             r_hsync;

  logic             w_adv;
  logic             w_line_end;
  logic             w_active;

  // One pixel step every CLK_DIV clocks; with CLK_DIV=1 the divider sits at 0
  // and w_adv is permanently high.
  assign w_adv      = (r_div_cnt == DIV_LAST);
  assign w_line_end = (r_hor_cnt == HC_LAST);
  assign w_active   = (r_hor_cnt >= ACT_FIRST) && (r_hor_cnt <= ACT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_adv) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hor_cnt <= '0;
    end else if (w_adv) begin
      if (w_line_end) begin
        r_hor_cnt <= '0;
      end else begin
        r_hor_cnt <= r_hor_cnt + 10'd1;
      end
    end
  end

  // Scaled column: held at 0 outside the window so the first visible pixel
  // always starts column 0 with a fresh sub-count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_int_cnt     <= '0;
      r_scl_hor_cnt <= '0;
    end else if (!w_active) begin
      r_int_cnt     <= '0;
      r_scl_hor_cnt <= '0;
    end else if (w_adv) begin
      if (r_int_cnt == INT_LAST) begin
        r_int_cnt     <= '0;
        r_scl_hor_cnt <= r_scl_hor_cnt + 7'd1;
      end else begin
        r_int_cnt <= r_int_cnt + 3'd1;
      end
    end
  end

  // Registered sync, one clock behind the counter decode like VSYNC downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync <= 1'b0;
    end else begin
      r_hsync <= (r_hor_cnt >= HS_END);
    end
  end

  assign hor_cnt     = r_hor_cnt;
  assign scl_hor_cnt = r_scl_hor_cnt;
  assign hor_active  = w_active;
  assign new_line    = w_adv && w_line_end;
  assign HSYNC       = r_hsync;

endmodule

// File: tb/tb_horizontal_counter_generator.sv
// Bench for horizontal_counter_generator: default CLK_DIV=2 instance and a
// CLK_DIV=1 instance running side by side from the same clock and reset.
module tb_horizontal_counter_generator;

  logic       clk;
  logic       reset;

  logic [9:0] hc2, hc1;
  logic [6:0] scl2, scl1;
  logic       act2, act1;
  logic       nl2, nl1;
  logic       hs2, hs1;

  int n_checks;
  int n_errors;

  int last_nl2, last_nl1;
  int low_cnt2, low_cnt1;
  bit seen_hi2, seen_hi1;

  horizontal_counter_generator u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .hor_cnt    (hc2),
    .scl_hor_cnt(scl2),
    .hor_active (act2),
    .new_line   (nl2),
    .HSYNC      (hs2)
  );

  horizontal_counter_generator #(.CLK_DIV(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .hor_cnt    (hc1),
    .scl_hor_cnt(scl1),
    .hor_active (act1),
    .new_line   (nl1),
    .HSYNC      (hs1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected position after n clk edges since reset release.
  function automatic int exp_hc(input int n, input int div);
    return (n / div) % 800;
  endfunction

  task automatic check_dut(input string pfx, input int n, input int div,
                           input logic [9:0] hc, input logic [6:0] scl,
                           input logic act, input logic nl, input logic hs);
    int e_hc;
    int e_act;
    int e_scl;
    int e_nl;
    int e_hs;
    e_hc  = exp_hc(n, div);
    e_act = (e_hc >= 144 && e_hc <= 783) ? 1 : 0;
    e_scl = e_act ? (e_hc - 144) / 5 : 0;
    e_nl  = ((n % div) == div - 1 && e_hc == 799) ? 1 : 0;
    e_hs  = (n == 0) ? 0 : ((exp_hc(n - 1, div) >= 96) ? 1 : 0);
    check({pfx, "_hor_cnt"}, hc, e_hc);
    check({pfx, "_hor_active"}, act, e_act);
    check({pfx, "_scl_hor_cnt"}, scl, e_scl);
    check({pfx, "_new_line"}, nl, e_nl);
    check({pfx, "_HSYNC"}, hs, e_hs);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hc2"}, hc2, 0);
    check({tag, "_scl2"}, scl2, 0);
    check({tag, "_act2"}, act2, 0);
    check({tag, "_nl2"}, nl2, 0);
    check({tag, "_hs2"}, hs2, 0);
    check({tag, "_hc1"}, hc1, 0);
    check({tag, "_scl1"}, scl1, 0);
    check({tag, "_act1"}, act1, 0);
    check({tag, "_nl1"}, nl1, 0);
    check({tag, "_hs1"}, hs1, 0);
  endtask

  // Hand-computed landmarks for the CLK_DIV=2 instance after n edges.
  task automatic check_landmarks(input int n);
    case (n)
      192:  check("hs_still_low_hc96", hs2, 0);
      193:  check("hs_rise", hs2, 1);
      286:  check("act_before_144", act2, 0);
      288:  begin check("act_rise_144", act2, 1); check("scl_at_144", scl2, 0); end
      296:  check("scl_at_148", scl2, 0);
      298:  check("scl_at_149", scl2, 1);
      1558: check("scl_at_779", scl2, 127);
      1566: begin check("scl_at_783", scl2, 127); check("act_at_783", act2, 1); end
      1568: begin check("scl_at_784", scl2, 0); check("act_fall_784", act2, 0); end
      1598: check("nl_low_div0", nl2, 0);
      1599: begin check("nl_first", nl2, 1); check("hc_799", hc2, 799); end
      1600: begin check("hc_wrap", hc2, 0); check("nl_one_wide", nl2, 0); check("hs_hi_hc799", hs2, 1); end
      1601: check("hs_fall", hs2, 0);
      1792: check("hs_low_end", hs2, 0);
      1793: check("hs_rise_line2", hs2, 1);
      default: ;
    endcase
  endtask

  // Per-line period and HSYNC low-width bookkeeping.
  task automatic track(input int n);
    if (nl2) begin
      if (last_nl2 >= 0) check("nl_period_div2", n - last_nl2, 1600);
      last_nl2 = n;
    end
    if (nl1) begin
      if (last_nl1 >= 0) check("nl_period_div1", n - last_nl1, 800);
      last_nl1 = n;
    end
    if (!hs2) begin
      if (seen_hi2) low_cnt2++;
    end else begin
      if (seen_hi2 && low_cnt2 > 0) check("hs_low_width_div2", low_cnt2, 192);
      low_cnt2 = 0;
      seen_hi2 = 1'b1;
    end
    if (!hs1) begin
      if (seen_hi1) low_cnt1++;
    end else begin
      if (seen_hi1 && low_cnt1 > 0) check("hs_low_width_div1", low_cnt1, 96);
      low_cnt1 = 0;
      seen_hi1 = 1'b1;
    end
  endtask

  // Call right after reset is released on a falling edge.
  task automatic run_lines(input int edges, input bit landmarks);
    last_nl2 = -1;
    last_nl1 = -1;
    low_cnt2 = 0;
    low_cnt1 = 0;
    seen_hi2 = 1'b0;
    seen_hi1 = 1'b0;
    for (int n = 0; n <= edges; n++) begin
      if (n > 0) @(posedge clk);
      #1;
      check_dut("d2", n, 2, hc2, scl2, act2, nl2, hs2);
      check_dut("d1", n, 1, hc1, scl1, act1, nl1, hs1);
      track(n);
      if (landmarks) check_landmarks(n);
    end
  endtask

  initial begin
    bit found;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

    @(negedge clk);
    reset = 1'b0;
    run_lines(20 * 1600, 1'b1);

    // Mid-line asynchronous reset at hor_cnt=500.
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (hc2 == 10'd500) begin
        found = 1'b1;
        break;
      end
    end
    check("wait_hc500", found, 1);
    #1;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_lines(2 * 1600, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
